// File: rtl/video_axis_timer.sv
// One axis of a video raster timer: a wrapping position counter with a
// registered ACTIVE/FRONT/SYNC/BACK phase machine and a chainable wrap strobe.
module video_axis_timer #(
    parameter int WIDTH    = 16,
    parameter int ACTIVE   = 480,
    parameter int FRONT    = 10,
    parameter int SYNC     = 2,
    parameter int BACK     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             CLK25MHZ,
    input  logic             RST_N,
    input  logic             enable,
    output logic [WIDTH-1:0] count_value,
    output logic [1:0]       phase,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam longint TOTAL = longint'(ACTIVE) + FRONT + SYNC + BACK;

    generate
        if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_seg
            $error("video_axis_timer: every segment must be at least 1 count");
        end
        if (TOTAL > (longint'(1) << WIDTH)) begin : g_bad_total
            $error("video_axis_timer: period does not fit in WIDTH bits");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] END_A = WIDTH'(ACTIVE - 1);
    localparam logic [WIDTH-1:0] END_F = WIDTH'(ACTIVE + FRONT - 1);
    localparam logic [WIDTH-1:0] END_S = WIDTH'(ACTIVE + FRONT + SYNC - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    phase_t           state_q;
    phase_t           state_d;
    logic [WIDTH-1:0] count_d;
    logic             last;

    assign last  = (count_value == LAST);
    assign wrap  = enable & RST_N & last;
    assign phase = state_q;

    // Transitions fire on the last count of a segment so the new phase
    // lands on the same edge as the first count of the next segment.
    always_comb begin
        state_d = state_q;
        count_d = count_value;
        if (enable) begin
            count_d = last ? '0 : count_value + WIDTH'(1);
            unique case (state_q)
                PH_ACTIVE: if (count_value == END_A) state_d = PH_FRONT;
                PH_FRONT:  if (count_value == END_F) state_d = PH_SYNC;
                PH_SYNC:   if (count_value == END_S) state_d = PH_BACK;
                PH_BACK:   if (last)                 state_d = PH_ACTIVE;
                default:   state_d = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge CLK25MHZ) begin
        if (!RST_N) begin
            count_value <= '0;
            state_q     <= PH_ACTIVE;
            sync        <= ~SYNC_POL;
            active      <= 1'b1;
        end else begin
            count_value <= count_d;
            state_q     <= state_d;
            sync        <= (state_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            active      <= (state_d == PH_ACTIVE);
        end
    end

endmodule

// File: tb/tb_video_axis_timer.sv
// Scoreboard bench: several timer configurations share enable/reset, a
// reference model queues expected outputs and a monitor compares each cycle.
module tb_video_axis_timer;

    logic CLK25MHZ = 1'b0;
    logic RST_N    = 1'b0;
    logic enable   = 1'b0;

    always #20 CLK25MHZ = ~CLK25MHZ;

    // A: defaults
    logic [15:0] ca; logic [1:0] pa; logic sa, aa, wa;
    // B: small, active-high sync
    logic [3:0]  cb; logic [1:0] pb; logic sb, ab, wb;
    // C: period exactly 2^10
    logic [9:0]  cc; logic [1:0] pc; logic sc, ac, wc;
    // H drives V
    logic [15:0] ch; logic [1:0] ph; logic sh, ah, wh;
    logic [15:0] cv; logic [1:0] pv; logic sv, av, wv;

    video_axis_timer u_a (
        .CLK25MHZ(CLK25MHZ), .RST_N(RST_N), .enable(enable),
        .count_value(ca), .phase(pa), .sync(sa), .active(aa), .wrap(wa));

    video_axis_timer #(.WIDTH(4), .ACTIVE(4), .FRONT(2), .SYNC(3), .BACK(1),
                       .SYNC_POL(1'b1)) u_b (
        .CLK25MHZ(CLK25MHZ), .RST_N(RST_N), .enable(enable),
        .count_value(cb), .phase(pb), .sync(sb), .active(ab), .wrap(wb));

    video_axis_timer #(.WIDTH(10), .ACTIVE(1000), .FRONT(8), .SYNC(8),
                       .BACK(8)) u_c (
        .CLK25MHZ(CLK25MHZ), .RST_N(RST_N), .enable(enable),
        .count_value(cc), .phase(pc), .sync(sc), .active(ac), .wrap(wc));

    video_axis_timer #(.ACTIVE(640), .FRONT(16), .SYNC(96), .BACK(48)) u_h (
        .CLK25MHZ(CLK25MHZ), .RST_N(RST_N), .enable(enable),
        .count_value(ch), .phase(ph), .sync(sh), .active(ah), .wrap(wh));

    video_axis_timer u_v (
        .CLK25MHZ(CLK25MHZ), .RST_N(RST_N), .enable(wh),
        .count_value(cv), .phase(pv), .sync(sv), .active(av), .wrap(wv));

    typedef struct {
        bit en; bit rn;
        int ca; int pa; bit sa; bit aa; bit wa;
        int cb; int pb; bit sb; bit ab; bit wb;
        int cc; int pc; bit wc;
        int ch; int ph; bit wh;
        int cv; int pv; bit wv;
    } item_t;

    item_t q[$];
    int checks = 0;
    int errors = 0;
    int ma = 0, mb = 0, mc = 0, mh = 0, mv = 0;

    function automatic int ph_of(int c, int a, int f, int s);
        if (c < a)         return 0;
        if (c < a + f)     return 1;
        if (c < a + f + s) return 2;
        return 3;
    endfunction

    function automatic int nxt(int c, int total, bit en, bit rn);
        if (!rn) return 0;
        if (!en) return c;
        return (c == total - 1) ? 0 : c + 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(bit en, bit rn);
        item_t it;
        @(negedge CLK25MHZ);
        enable = en;
        RST_N  = rn;
        it.en = en; it.rn = rn;
        it.ca = ma; it.pa = ph_of(ma, 480, 10, 2);
        it.sa = (it.pa != 2); it.aa = (it.pa == 0);
        it.wa = en & rn & (ma == 524);
        it.cb = mb; it.pb = ph_of(mb, 4, 2, 3);
        it.sb = (it.pb == 2); it.ab = (it.pb == 0);
        it.wb = en & rn & (mb == 9);
        it.cc = mc; it.pc = ph_of(mc, 1000, 8, 8);
        it.wc = en & rn & (mc == 1023);
        it.ch = mh; it.ph = ph_of(mh, 640, 16, 96);
        it.wh = en & rn & (mh == 799);
        it.cv = mv; it.pv = ph_of(mv, 480, 10, 2);
        it.wv = it.wh & rn & (mv == 524);
        q.push_back(it);
        ma = nxt(ma, 525, en, rn);
        mb = nxt(mb, 10, en, rn);
        mc = nxt(mc, 1024, en, rn);
        mh = nxt(mh, 800, en, rn);
        mv = nxt(mv, 525, it.wh, rn);
    endtask

    task automatic run_to(int tgt);
        for (int i = 0; i < 600 && ma != tgt; i++) cyc(1'b1, 1'b1);
    endtask

    // Monitor: one expected snapshot per cycle, plus a wrap-interval count
    initial begin : monitor
        item_t it;
        int since = 0;
        bit seen = 0;
        forever begin
            @(negedge CLK25MHZ);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                chk("a_count", ca, it.ca);
                chk("a_phase", pa, it.pa);
                chk("a_sync", sa, it.sa);
                chk("a_active", aa, it.aa);
                chk("a_wrap", wa, it.wa);
                chk("b_count", cb, it.cb);
                chk("b_phase", pb, it.pb);
                chk("b_sync", sb, it.sb);
                chk("b_active", ab, it.ab);
                chk("b_wrap", wb, it.wb);
                chk("c_count", cc, it.cc);
                chk("c_phase", pc, it.pc);
                chk("c_wrap", wc, it.wc);
                chk("h_count", ch, it.ch);
                chk("h_phase", ph, it.ph);
                chk("h_wrap", wh, it.wh);
                chk("v_count", cv, it.cv);
                chk("v_phase", pv, it.pv);
                chk("v_wrap", wv, it.wv);
                if (!it.rn) begin
                    seen = 0;
                    since = 0;
                end else begin
                    if (wa === 1'b1) begin
                        if (seen) chk("a_wrap_interval", since, 525);
                        seen = 1;
                        since = 0;
                    end
                    if (it.en) since++;
                end
            end
        end
    end

    initial begin : stimulus
        void'($urandom(32'h1234));
        RST_N  = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge CLK25MHZ);
        // free run: two full periods of the default axis
        for (int i = 0; i < 1050; i++) cyc(1'b1, 1'b1);
        // hold behaviour under random enable
        for (int i = 0; i < 1600; i++) cyc(1'($urandom_range(0, 1)), 1'b1);
        // reset pulses mid-active, mid-sync, at terminal count, while held
        run_to(300); cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        run_to(491); cyc(1'b1, 1'b0);
        run_to(524); cyc(1'b1, 1'b0);
        run_to(100); cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        // let the chained vertical axis advance several lines
        for (int i = 0; i < 2500; i++) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        @(negedge CLK25MHZ);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
